// File: rtl/rc5_pkg.sv
// rc5_pkg: shared definitions for the RC5 key-expansion L loader.
//   - state_t: FSM state encoding used by rc5_key_expand_loader
//   - BYTE_W: key byte width
//   - w_legal(): legal RC5 word widths (16/32/64)
//   - clog2_min1(), ceil_div(): width and word-count helpers
package rc5_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic bit w_legal(input int w);
    return (w == 16) || (w == 32) || (w == 64);
  endfunction

  // Address widths never collapse to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int ceil_div(input int a, input int d);
    return (a + d - 1) / d;
  endfunction

endpackage

// File: rtl/rc5_key_expand_loader_packer.sv
// rc5_byte_packer: byte-to-word packer for the RC5 L loader.
// Tags each key-RAM read with a 1-cycle valid/index pipe so the byte can be
// matched to its index when it returns, shifts it into the accumulator and
// emits a registered L write when the byte lands on a word boundary.
// A forced write (frc_we) stores zero at frc_addr; the FSM only raises it
// when no key byte is in flight.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rd_vld, rd_idx      key read issued this cycle and its byte index
//   key_data            key RAM data (1-cycle latency)
//   frc_we, frc_addr    zero-write request from the FSM
//   l_we, l_addr, l_data  registered L RAM write port
module rc5_byte_packer
  import rc5_pkg::*;
#(
  parameter int W    = 32,
  parameter int KA_W = 4,
  parameter int LA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_vld,
  input  logic [KA_W-1:0]   rd_idx,
  input  logic [BYTE_W-1:0] key_data,
  input  logic              frc_we,
  input  logic [LA_W-1:0]   frc_addr,
  output logic              l_we,
  output logic [LA_W-1:0]   l_addr,
  output logic [W-1:0]      l_data
);

  localparam int U = W / BYTE_W;

  logic              vld_q, vld_d;
  logic [KA_W-1:0]   idx_q, idx_d;
  logic [W-1:0]      acc_q, acc_d, acc_new;
  logic              l_we_q, l_we_d;
  logic [LA_W-1:0]   l_addr_q, l_addr_d;
  logic [W-1:0]      l_data_q, l_data_d;

  assign acc_new = {acc_q[W-BYTE_W-1:0], key_data};

  always_comb begin
    vld_d    = rd_vld;
    idx_d    = rd_idx;
    acc_d    = acc_q;
    l_we_d   = 1'b0;
    l_addr_d = '0;
    l_data_d = '0;
    if (vld_q) begin
      acc_d = acc_new;
      // Lowest byte of a word closes it; high bytes of a partial top word
      // were never shifted in, so they read as zero.
      if ((int'(idx_q) % U) == 0) begin
        l_we_d   = 1'b1;
        l_addr_d = LA_W'(int'(idx_q) / U);
        l_data_d = acc_new;
        acc_d    = '0;
      end
    end else if (frc_we) begin
      l_we_d   = 1'b1;
      l_addr_d = frc_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      l_we_q   <= 1'b0;
      l_addr_q <= '0;
      l_data_q <= '0;
    end else begin
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      l_we_q   <= l_we_d;
      l_addr_q <= l_addr_d;
      l_data_q <= l_data_d;
    end
  end

  assign l_we   = l_we_q;
  assign l_addr = l_addr_q;
  assign l_data = l_data_q;

endmodule

// File: rtl/rc5_key_expand_loader.sv
// rc5_key_expand_loader: streams key bytes K[b-1..0] from the key RAM into
// the RC5 L array, one byte per cycle, L[c-1] written first down to L[0].
// Optional macro RC5_L_CLEAR_EN: after the key words, zero L[c..CMAX-1] in
// ascending order before signalling done.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, key_len     load request and key length (clamped to BMAX)
//   busy, done         handshake; done is a one-cycle pulse
//   c_count            words written, max(1, ceil(b/U))
//   key_re, key_addr, key_data   key RAM read port (1-cycle latency)
//   l_we, l_addr, l_data         L RAM write port
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing key reads, i = b-1 down to 0
// DRAIN   | last byte returning; empty key issues a single zero write
// CLEAR   | zeroing L[c..CMAX-1] (RC5_L_CLEAR_EN only)
// DONE    | one-cycle completion pulse
module rc5_key_expand_loader
  import rc5_pkg::*;
#(
  parameter  int W    = 32,
  parameter  int BMAX = 16,
  localparam int U    = W / 8,
  localparam int CMAX = (ceil_div(BMAX, U) < 1) ? 1 : ceil_div(BMAX, U),
  localparam int KA_W = clog2_min1(BMAX),
  localparam int LA_W = clog2_min1(CMAX)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      key_len,
  output logic            busy,
  output logic            done,
  output logic [LA_W:0]   c_count,
  output logic            key_re,
  output logic [KA_W-1:0] key_addr,
  input  logic [7:0]      key_data,
  output logic            l_we,
  output logic [LA_W-1:0] l_addr,
  output logic [W-1:0]    l_data
);

  localparam int CW = LA_W + 1;

  if (!w_legal(W)) begin : g_w_illegal
    $error("rc5_key_expand_loader: W must be 16, 32 or 64");
  end

  state_t            state_q, state_d;
  logic [7:0]        b_q, b_d;
  logic [CW-1:0]     c_q, c_d;
  logic              key_re_q, key_re_d;
  logic [KA_W-1:0]   key_addr_q, key_addr_d;
  logic              frc_we;
  logic [LA_W-1:0]   frc_addr;
`ifdef RC5_L_CLEAR_EN
  logic [CW-1:0]     clr_ptr_q, clr_ptr_d;
`endif

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    c_d        = c_q;
    key_re_d   = 1'b0;
    key_addr_d = key_addr_q;
    frc_we     = 1'b0;
    frc_addr   = '0;
`ifdef RC5_L_CLEAR_EN
    clr_ptr_d  = clr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d = (key_len > 8'(BMAX)) ? 8'(BMAX) : key_len;
          c_d = (b_d == 8'd0) ? CW'(1) : CW'(ceil_div(int'(b_d), U));
          if (b_d != 8'd0) begin
            state_d    = S_FETCH;
            key_re_d   = 1'b1;
            key_addr_d = KA_W'(b_d - 8'd1);
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_FETCH: begin
        // key_addr_q is the read in flight this cycle; it doubles as i.
        if (key_addr_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          key_re_d   = 1'b1;
          key_addr_d = key_addr_q - KA_W'(1);
        end
      end
      S_DRAIN: begin
        // The L[0] write is always the last key write, including b = 0.
        if (l_we && (l_addr == '0)) begin
`ifdef RC5_L_CLEAR_EN
          if (c_q < CW'(CMAX)) begin
            state_d   = S_CLEAR;
            frc_we    = 1'b1;
            frc_addr  = LA_W'(c_q);
            clr_ptr_d = c_q + CW'(1);
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else if ((b_q == 8'd0) && !l_we) begin
          frc_we = 1'b1;
        end
      end
`ifdef RC5_L_CLEAR_EN
      S_CLEAR: begin
        if (clr_ptr_q == CW'(CMAX)) begin
          state_d = S_DONE;
        end else begin
          frc_we    = 1'b1;
          frc_addr  = LA_W'(clr_ptr_q);
          clr_ptr_d = clr_ptr_q + CW'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      c_q        <= '0;
      key_re_q   <= 1'b0;
      key_addr_q <= '0;
`ifdef RC5_L_CLEAR_EN
      clr_ptr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      c_q        <= c_d;
      key_re_q   <= key_re_d;
      key_addr_q <= key_addr_d;
`ifdef RC5_L_CLEAR_EN
      clr_ptr_q  <= clr_ptr_d;
`endif
    end
  end

  rc5_byte_packer #(
    .W   (W),
    .KA_W(KA_W),
    .LA_W(LA_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_vld  (key_re_q),
    .rd_idx  (key_addr_q),
    .key_data(key_data),
    .frc_we  (frc_we),
    .frc_addr(frc_addr),
    .l_we    (l_we),
    .l_addr  (l_addr),
    .l_data  (l_data)
  );

  assign busy     = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_CLEAR);
  assign done     = (state_q == S_DONE);
  assign c_count  = c_q;
  assign key_re   = key_re_q;
  assign key_addr = key_addr_q;

endmodule

// File: tb/tb_rc5_key_expand_loader.sv
module tb_rc5_key_expand_loader;

`ifdef RC5_L_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] key_len = 8'd0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  // DUT A: W=32, BMAX=16
  logic        busy_a, done_a, key_re_a, l_we_a;
  logic [2:0]  c_a;
  logic [3:0]  kaddr_a;
  logic [7:0]  kdata_a = 8'd0;
  logic [1:0]  laddr_a;
  logic [31:0] ldata_a;

  // DUT B: W=16, BMAX=8
  logic        busy_b, done_b, key_re_b, l_we_b;
  logic [2:0]  c_b;
  logic [2:0]  kaddr_b;
  logic [7:0]  kdata_b = 8'd0;
  logic [1:0]  laddr_b;
  logic [15:0] ldata_b;

  rc5_key_expand_loader #(.W(32), .BMAX(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .key_len(key_len),
    .busy(busy_a), .done(done_a), .c_count(c_a),
    .key_re(key_re_a), .key_addr(kaddr_a), .key_data(kdata_a),
    .l_we(l_we_a), .l_addr(laddr_a), .l_data(ldata_a));

  rc5_key_expand_loader #(.W(16), .BMAX(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .key_len(key_len),
    .busy(busy_b), .done(done_b), .c_count(c_b),
    .key_re(key_re_b), .key_addr(kaddr_b), .key_data(kdata_b),
    .l_we(l_we_b), .l_addr(laddr_b), .l_data(ldata_b));

  logic [7:0] kmem [256];

  always @(posedge clk) begin
    if (key_re_a) kdata_a <= kmem[kaddr_a];
    if (key_re_b) kdata_b <= kmem[kaddr_b];
  end

  logic        m_busy, m_done, m_re, m_we;
  logic [2:0]  m_c;
  logic [7:0]  m_kaddr;
  logic [1:0]  m_laddr;
  logic [63:0] m_ldata;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_re    = sel ? key_re_b : key_re_a;
  assign m_we    = sel ? l_we_b : l_we_a;
  assign m_c     = sel ? c_b : c_a;
  assign m_kaddr = sel ? 8'(kaddr_b) : 8'(kaddr_a);
  assign m_laddr = sel ? laddr_b : laddr_a;
  assign m_ldata = sel ? 64'(ldata_b) : 64'(ldata_a);

  int n_vec = 0;
  int n_bad = 0;
  int done_at;
  logic [63:0] cap_addr[$];
  logic [63:0] cap_data[$];

  task automatic check(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, t, act, exp);
    end
  endtask

  // L[w] collects key bytes i with i/u == w, byte i%u at bit 8*(i%u).
  function automatic logic [63:0] exp_word(input int b, input int u, input int w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < b; i++)
      if (i / u == w) v = v | (64'(kmem[i]) << (8 * (i % u)));
    return v;
  endfunction

  task automatic run_load(input bit s, input int len, input int repulse,
                          input int bmax, input int u, input int cmax);
    int b, c, nclr, td;
    logic ew;
    logic [63:0] ea, ed;
    b    = (len > bmax) ? bmax : len;
    c    = (b == 0) ? 1 : (b + u - 1) / u;
    nclr = CLR ? cmax - c : 0;
    td   = b + 2 + nclr;
    cap_addr.delete();
    cap_data.delete();
    done_at = -1;
    sel = s;
    @(posedge clk); #1 start = 1'b1; key_len = 8'(len);
    @(posedge clk); #1 start = 1'b0; key_len = 8'd2;
    for (int t = 0; t <= td + 1; t++) begin
      start = (t == repulse);
      @(negedge clk);
      ew = 1'b0; ea = '0; ed = '0;
      for (int w = 0; w < c; w++)
        if (t == b - w * u + 1) begin ew = 1'b1; ea = 64'(w); ed = exp_word(b, u, w); end
      for (int k = 0; k < nclr; k++)
        if (t == b + 2 + k) begin ew = 1'b1; ea = 64'(c + k); ed = '0; end
      check("busy", t, m_busy, t < td);
      check("done", t, m_done, t == td);
      check("key_re", t, m_re, (b > 0) && (t < b));
      if ((b > 0) && (t < b)) check("key_addr", t, m_kaddr, 64'(b - 1 - t));
      check("l_we", t, m_we, ew);
      if (ew) begin
        check("l_addr", t, m_laddr, ea);
        check("l_data", t, m_ldata, ed);
      end
      if (t >= td) check("c_count", t, m_c, 64'(c));
      if (m_we) begin cap_addr.push_back(64'(m_laddr)); cap_data.push_back(m_ldata); end
      if (m_done && done_at < 0) done_at = t;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  logic [63:0] lit_full [4];
  logic [63:0] lit_part [2];

  initial begin
    lit_full = '{64'h0F0E0D0C, 64'h0B0A0908, 64'h07060504, 64'h03020100};
    lit_part = '{64'h00000004, 64'h03020100};
    for (int i = 0; i < 256; i++) kmem[i] = 8'(i);

    #2;
    check("rst busy_a", -1, busy_a, 0);
    check("rst done_a", -1, done_a, 0);
    check("rst key_re_a", -1, key_re_a, 0);
    check("rst l_we_a", -1, l_we_a, 0);
    check("rst l_data_a", -1, ldata_a, 0);
    check("rst c_a", -1, c_a, 0);
    check("rst l_we_b", -1, l_we_b, 0);
    check("rst busy_b", -1, busy_b, 0);
    #20 rst_n = 1'b1;

    // model pins
    check("model L3 b16", 0, exp_word(16, 4, 3), 64'h0F0E0D0C);
    check("model L1 b5", 0, exp_word(5, 4, 1), 64'h4);

    // full key
    run_load(1'b0, 16, -1, 16, 4, 4);
    check("full done_cycle", 0, done_at, 18);
    check("full c", 0, m_c, 4);
    check("full nwr", 0, cap_addr.size(), 4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      check("full wr_addr", i, cap_addr[i], 64'(3 - i));
      check("full wr_data", i, cap_data[i], lit_full[i]);
    end

    // partial key
    run_load(1'b0, 5, -1, 16, 4, 4);
    check("part done_cycle", 0, done_at, CLR ? 9 : 7);
    check("part c", 0, m_c, 2);
    check("part nwr", 0, cap_addr.size(), CLR ? 4 : 2);
    for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
      check("part wr_addr", i, cap_addr[i], 64'(1 - i));
      check("part wr_data", i, cap_data[i], lit_part[i]);
    end

    // empty key
    run_load(1'b0, 0, -1, 16, 4, 4);
    check("empty done_cycle", 0, done_at, CLR ? 5 : 2);
    check("empty c", 0, m_c, 1);
    check("empty nwr", 0, cap_addr.size(), CLR ? 4 : 1);
    if (cap_addr.size() > 0) begin
      check("empty wr_addr", 0, cap_addr[0], 0);
      check("empty wr_data", 0, cap_data[0], 0);
    end

    // clamp 20 -> 16 with start re-pulsed in cycle 3
    run_load(1'b0, 20, 3, 16, 4, 4);
    check("clamp done_cycle", 0, done_at, 18);
    check("clamp c", 0, m_c, 4);
    check("clamp nwr", 0, cap_addr.size(), 4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++)
      check("clamp wr_data", i, cap_data[i], lit_full[i]);

    // reset mid-load in cycle 6
    sel = 1'b0;
    @(posedge clk); #1 start = 1'b1; key_len = 8'd16;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst busy", 6, busy_a, 0);
    check("arst key_re", 6, key_re_a, 0);
    check("arst key_addr", 6, kaddr_a, 0);
    check("arst l_we", 6, l_we_a, 0);
    check("arst l_addr", 6, laddr_a, 0);
    check("arst l_data", 6, ldata_a, 0);
    check("arst c", 6, c_a, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post-rst l_we", 7, l_we_a, 0);
      check("post-rst busy", 7, busy_a, 0);
    end
    run_load(1'b0, 4, -1, 16, 4, 4);
    check("after-rst done_cycle", 0, done_at, CLR ? 9 : 6);
    if (cap_data.size() > 0) check("after-rst L0", 0, cap_data[0], 64'h03020100);

    // W=16, BMAX=8, K = {AA, BB, CC}
    kmem[0] = 8'hAA; kmem[1] = 8'hBB; kmem[2] = 8'hCC;
    check("model L0 w16", 0, exp_word(3, 2, 0), 64'hBBAA);
    run_load(1'b1, 3, -1, 8, 2, 4);
    check("w16 done_cycle", 0, done_at, CLR ? 7 : 5);
    check("w16 c", 0, m_c, 2);
    check("w16 nwr", 0, cap_addr.size(), CLR ? 4 : 2);
    if (cap_data.size() >= 2) begin
      check("w16 L1", 0, cap_data[0], 64'h00CC);
      check("w16 L0", 1, cap_data[1], 64'hBBAA);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
